// File: rtl/out_port_sw_arbiter_pkg.sv
// Shared definitions for the per-output-port switch arbiter: port indices,
// default sizing and the arbiter state encoding.
package out_port_sw_arbiter_pkg;

    localparam int P_DEFAULT     = 5;
    localparam int CNT_W_DEFAULT = 8;

    localparam int PORT_EAST  = 0;
    localparam int PORT_WEST  = 1;
    localparam int PORT_NORTH = 2;
    localparam int PORT_SOUTH = 3;
    localparam int PORT_LOCAL = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/out_port_sw_arbiter_if.sv
// Request/grant bundle between the input ports and one output-port arbiter.
// The input-port side is the master, the arbiter is the slave.
interface out_port_sw_arbiter_if
    import out_port_sw_arbiter_pkg::*;
#(
    parameter int P     = P_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
);
    logic [P-1:0]     req;
    logic [P-1:0]     req_tail;
    logic             credit_avail;
    logic [P-1:0]     grant;
    logic             grant_valid;
    logic             flit_fire;
    logic [P-1:0]     grant_pop;
    logic [CNT_W-1:0] pkt_flit_cnt;

    modport master (
        output req, req_tail, credit_avail,
        input  grant, grant_valid, flit_fire, grant_pop, pkt_flit_cnt
    );

    modport slave (
        input  req, req_tail, credit_avail,
        output grant, grant_valid, flit_fire, grant_pop, pkt_flit_cnt
    );
endinterface

// File: rtl/out_port_sw_arbiter_rr_priority_enc.sv
// Round-robin priority encoder: one-hot winner among i_req, searching upward
// from the position just after the one-hot pointer i_ptr and wrapping around.
module rr_priority_enc #(
    parameter int P = 5
) (
    input  logic [P-1:0] i_req,
    input  logic [P-1:0] i_ptr,
    output logic [P-1:0] o_winner
);
    logic [P-1:0]   w_above;
    logic [2*P-1:0] w_dbl;
    logic [2*P-1:0] w_first;

    // w_above marks positions strictly above the pointer; those are searched first.
    always_comb begin
        logic v_seen;
        v_seen  = 1'b0;
        w_above = '0;
        for (int j = 0; j < P; j++) begin
            w_above[j] = v_seen;
            v_seen     = v_seen | i_ptr[j];
        end
    end

    // Lower copy holds the post-pointer requests, upper copy the wrapped-around ones.
    assign w_dbl    = {i_req, i_req & w_above};
    assign w_first  = w_dbl & (-w_dbl);
    assign o_winner = w_first[P-1:0] | w_first[2*P-1:P];

endmodule

// File: rtl/out_port_sw_arbiter.sv
// Output-port switch arbiter: wormhole packet locking with round-robin fairness,
// registered one-hot grant for the output mux and a per-flit transfer strobe.
module out_port_sw_arbiter
    import out_port_sw_arbiter_pkg::*;
#(
    parameter int P     = P_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  reset,
    out_port_sw_arbiter_if.slave  bus
);
    arb_state_t       r_state,  w_state_nxt;
    logic [P-1:0]     r_grant,  w_grant_nxt;
    logic [P-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [P-1:0]     w_winner;
    logic             w_fire;
    logic             w_tail;

    rr_priority_enc #(.P(P)) u_rr_enc (
        .i_req    (bus.req),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_winner)
    );

    assign w_fire = (r_state == ST_LOCKED) & (|(r_grant & bus.req)) & bus.credit_avail;
    assign w_tail = |(r_grant & bus.req_tail);

    // NOTE: every next-state signal is defaulted to its current value first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_ptr_nxt = r_rr_ptr;
        w_cnt_nxt    = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (|bus.req) begin
                    w_grant_nxt = w_winner;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (w_fire) begin
                    if (w_tail) begin
                        // Pointer moves only on release, so the next search starts after this owner.
                        w_rr_ptr_nxt = r_grant;
                        w_grant_nxt  = '0;
                        w_cnt_nxt    = '0;
                        w_state_nxt  = ST_IDLE;
                    end else if (r_cnt != '1) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked block and the sensitivity list holds only the clock.
    // NOTE: state registers use non-blocking assignments so all of them update together from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= {1'b1, {(P-1){1'b0}}};
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign bus.grant        = r_grant;
    assign bus.grant_valid  = (r_state == ST_LOCKED);
    assign bus.flit_fire    = w_fire;
    assign bus.grant_pop    = r_grant & {P{w_fire}};
    assign bus.pkt_flit_cnt = r_cnt;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(r_grant));
    a_valid_match:   assert property (@(posedge clk) disable iff (reset) bus.grant_valid == (|r_grant));
    a_fire_locked:   assert property (@(posedge clk) disable iff (reset) w_fire |-> bus.grant_valid);
    a_pop_onehot0:   assert property (@(posedge clk) disable iff (reset) $onehot0(bus.grant_pop));

endmodule

// File: tb/tb_out_port_sw_arbiter.sv
// Self-checking bench for out_port_sw_arbiter: a behavioural reference model
// pushes the expected registered state per cycle to a scoreboard queue.
module tb_out_port_sw_arbiter;
    import out_port_sw_arbiter_pkg::*;

    localparam int P       = 5;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [P-1:0]     grant;
        logic             valid;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    out_port_sw_arbiter_if #(.P(P), .CNT_W(CNT_W)) u_if ();

    out_port_sw_arbiter #(.P(P), .CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model state: owner index, pointer index, counter.
    bit   m_locked;
    int   m_w;
    int   m_ptr;
    int   m_cnt;
    int   dut_pkts[P];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check comb outputs, advance model, check registered state.
    task automatic cycle(input logic [P-1:0] req, input logic [P-1:0] tail,
                         input logic credit, input logic rst);
        logic exp_fire;
        exp_t e;
        exp_t got;
        reset            = rst;
        u_if.req         = req;
        u_if.req_tail    = tail;
        u_if.credit_avail = credit;
        #1;
        exp_fire = m_locked && req[m_w] && credit;
        check("flit_fire", 32'(u_if.flit_fire), 32'(exp_fire));
        check("grant_pop", 32'(u_if.grant_pop), exp_fire ? (32'd1 << m_w) : 32'd0);
        if (!rst && u_if.flit_fire && |(u_if.grant & tail))
            for (int i = 0; i < P; i++)
                if (u_if.grant[i]) dut_pkts[i]++;

        if (rst) begin
            m_locked = 1'b0;
            m_ptr    = P - 1;
            m_cnt    = 0;
        end else if (!m_locked) begin
            if (req != '0) begin
                for (int k = 1; k <= P; k++) begin
                    int idx;
                    idx = (m_ptr + k) % P;
                    if (req[idx]) begin
                        m_w      = idx;
                        m_locked = 1'b1;
                        m_cnt    = 0;
                        break;
                    end
                end
            end
        end else if (exp_fire) begin
            if (tail[m_w]) begin
                m_ptr    = m_w;
                m_locked = 1'b0;
                m_cnt    = 0;
            end else if (m_cnt < CNT_MAX) begin
                m_cnt++;
            end
        end
        e.grant = m_locked ? P'(1 << m_w) : '0;
        e.valid = m_locked;
        e.cnt   = CNT_W'(m_cnt);
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check("grant",        32'(u_if.grant),        32'(got.grant));
        check("grant_valid",  32'(u_if.grant_valid),  32'(got.valid));
        check("pkt_flit_cnt", 32'(u_if.pkt_flit_cnt), 32'(got.cnt));
    endtask

    task automatic do_reset();
        cycle('0, '0, 1'b1, 1'b1);
    endtask

    initial begin
        int mn;
        int mx;
        reset             = 1'b1;
        u_if.req          = '0;
        u_if.req_tail     = '0;
        u_if.credit_avail = 1'b0;
        m_locked = 1'b0;
        m_w      = 0;
        m_ptr    = P - 1;
        m_cnt    = 0;
        for (int i = 0; i < P; i++) dut_pkts[i] = 0;
        @(posedge clk);
        #1;
        check("reset_grant", 32'(u_if.grant),        32'd0);
        check("reset_valid", 32'(u_if.grant_valid),  32'd0);
        check("reset_cnt",   32'(u_if.pkt_flit_cnt), 32'd0);

        // 1: three sparse requesters, single-flit packets, grants 0,2,4,0,2 with bubbles.
        for (int k = 0; k < 12; k++) cycle(5'b10101, 5'b11111, 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);

        // 2: 4-flit packet on input 1; input 3 arrives mid-packet and must wait.
        do_reset();
        cycle(5'b00010, 5'b00000, 1'b1, 1'b0);
        cycle(5'b00010, 5'b00000, 1'b1, 1'b0);
        cycle(5'b01010, 5'b00000, 1'b1, 1'b0);
        cycle(5'b01010, 5'b00000, 1'b1, 1'b0);
        cycle(5'b01010, 5'b01010, 1'b1, 1'b0);
        cycle(5'b01000, 5'b01000, 1'b1, 1'b0);
        cycle(5'b01000, 5'b01000, 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);

        // 3: credit stall mid-packet on input 2; tail flag on a stalled cycle is ignored.
        do_reset();
        cycle(5'b00100, 5'b00000, 1'b1, 1'b0);
        cycle(5'b00100, 5'b00000, 1'b1, 1'b0);
        cycle(5'b00100, 5'b00100, 1'b0, 1'b0);
        cycle(5'b00100, 5'b00000, 1'b0, 1'b0);
        cycle(5'b11111, 5'b00000, 1'b0, 1'b0);
        cycle(5'b00100, 5'b00000, 1'b1, 1'b0);
        cycle(5'b00100, 5'b00100, 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);

        // 4: bubble on the owning input 0; no fire and no release until tail.
        do_reset();
        cycle(5'b00001, 5'b00000, 1'b1, 1'b0);
        cycle(5'b00001, 5'b00000, 1'b1, 1'b0);
        cycle(5'b10000, 5'b00001, 1'b1, 1'b0);
        cycle(5'b10000, 5'b00000, 1'b1, 1'b0);
        cycle(5'b10001, 5'b00000, 1'b1, 1'b0);
        cycle(5'b10001, 5'b00001, 1'b1, 1'b0);
        cycle('0, '0, 1'b1, 1'b0);

        // 5: reset after 3 fires of a 6-flit packet; then input 0 wins first.
        do_reset();
        cycle(5'b01000, 5'b00000, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) cycle(5'b01000, 5'b00000, 1'b1, 1'b0);
        cycle(5'b01000, 5'b00000, 1'b1, 1'b1);
        cycle(5'b11111, 5'b00000, 1'b1, 1'b0);
        check("post_reset_grant", 32'(u_if.grant), 32'd1);
        cycle(5'b11111, 5'b00001, 1'b1, 1'b0);

        // Counter saturation on a long packet.
        do_reset();
        for (int k = 0; k < 301; k++) cycle(5'b00010, 5'b00000, 1'b1, 1'b0);
        cycle(5'b00010, 5'b00010, 1'b1, 1'b0);

        // 6: saturated random traffic; fairness from DUT-observed packet completions.
        do_reset();
        for (int i = 0; i < P; i++) dut_pkts[i] = 0;
        for (int k = 0; k < 10000; k++)
            cycle(5'b11111, P'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0), 1'b0);
        mn = dut_pkts[0];
        mx = dut_pkts[0];
        for (int i = 1; i < P; i++) begin
            if (dut_pkts[i] < mn) mn = dut_pkts[i];
            if (dut_pkts[i] > mx) mx = dut_pkts[i];
        end
        check("fairness_spread_le1", 32'(mx - mn <= 1), 32'd1);
        check("random_pkts_nonzero", 32'(mn > 0), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
